fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the 4-bit CPU. Sits directly upstream of the decoder and executor, and drives the address of the combinational program ROM (4-bit address in, 8-bit word out).
- Holds the program counter (PC) and latches each ROM word into an instruction register.
- Presents each instruction as opcode[7:4] and immediate[3:0] under a valid/ready handshake.
- Accepts jump redirects and a halt request from the executor.

Parameters:
- ADDR_W, 4, PC / ROM address width.
- DATA_W, 8, ROM word width. Opcode is the upper DATA_W-ADDR_W bits; immediate is the lower ADDR_W bits.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rom_addr  out  ADDR_W  address to program ROM; equals pc, combinational.
- rom_data  in  DATA_W  ROM word for rom_addr, valid same cycle.
- instr_valid  out  1  instruction register holds an unconsumed instruction.
- instr_ready  in  1  executor accepts the instruction this cycle.
- opcode  out  4  IR[7:4].
- imm  out  4  IR[3:0].
- instr_pc  out  ADDR_W  address the current IR was fetched from.
- jump_en  in  1  qualifies jump_addr; meaningful only on an accept cycle.
- jump_addr  in  ADDR_W  redirect target.
- halt  in  1  level; stop fetching while high.
- halted  out  1  fetch stopped and no instruction outstanding.
- pc  out  ADDR_W  next fetch address (debug).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While rst_n=0:
  - pc=RESET_PC; IR=00; instr_pc=0; instr_valid=0; halted=0.
  - State = FETCH.
- Accept: accept = instr_valid & instr_ready. All updates happen on the rising clk edge.
- State FETCH:
  - halt=1: go to HALTED, set halted=1, no latch.
  - Otherwise: IR<=rom_data, instr_pc<=pc, pc<=pc+1 (mod 2^ADDR_W, 15 wraps to 0), instr_valid<=1, go to HOLD.
  - First instruction_valid appears 1 cycle after reset release.
- State HOLD (instr_valid=1):
  - No accept: IR, instr_pc, pc and instr_valid are held stable. halt does not drop a presented instruction.
  - Accept with jump_en=1: pc<=jump_addr, instr_valid<=0, go to FETCH. This costs one bubble cycle. Jump to the current pc or to itself is legal.
  - Accept with jump_en=0 and halt=0: back-to-back refill. IR<=rom_data, instr_pc<=pc, pc<=pc+1, stay in HOLD. Throughput is 1 instruction/cycle.
  - Accept with jump_en=0 and halt=1: instr_valid<=0, go to HALTED, set halted=1.
- State HALTED:
  - instr_valid=0; pc frozen.
  - When halt=0: go to FETCH and clear halted. The next fetch comes from the frozen pc.
- jump_en outside an accept cycle is ignored; pc is unchanged.
- Simultaneous jump_en and halt on an accept: the jump wins for pc (pc<=jump_addr), then the block enters HALTED. The jump target is fetched after resume.
- Wrap-around: after instr_pc=15 with no jump, the next instruction comes from address 0. No error flag.
- Reset mid-operation: asynchronous. An outstanding instruction is discarded, and the block restarts at RESET_PC on the first edge after release.
- opcode, imm and instr_pc hold their last values when instr_valid=0. Consumers must qualify them with instr_valid.
- rom_addr is never registered. The ROM is combinational, so a word fetched at pc is latched the same edge.

Test Plan:
Bench ROM model: 0:30, 1:60, 2:C0, 3:5F, 4:F2, 5:80, 6:A0, all other addresses 00.
1. Reset release, instr_ready=1 tied:
   - valid first rises 1 cycle after release.
   - Stream (instr_pc, opcode, imm) = (0,3,0), (1,6,0), (2,C,0), (3,5,F), (4,F,2), ... on consecutive cycles.
2. instr_ready=0 for 3 cycles while IR holds 5F: opcode=5, imm=F, instr_pc=3 and pc=4 stay stable; on accept, the next IR is F2.
3. Accept at instr_pc=4 with jump_en=1, jump_addr=2: one cycle with instr_valid=0, then IR=C0 with instr_pc=2.
4. Free-run from reset with no jumps:
   - after instr_pc=15 (word 00), the next instruction has instr_pc=0 and IR=30.
5. halt=1 asserted while IR=60 is pending unaccepted:
   - instr_valid stays 1 until the accept.
   - Then instr_valid=0, halted=1, pc=2.
   - Releasing halt yields IR=C0 two cycles later.
6. rst_n pulsed low mid-stream at instr_pc=5:
   - instr_valid drops asynchronously; pc=0.
   - After release, IR=30 with instr_pc=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the combinational program ROM
// and presents each latched word as opcode/immediate under a valid/ready handshake.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_W-ADDR_W-1:0] opcode,
  output logic [ADDR_W-1:0]        imm,
  output logic [ADDR_W-1:0]        instr_pc,
  input  logic                     jump_en,
  input  logic [ADDR_W-1:0]        jump_addr,
  input  logic                     halt,
  output logic                     halted,
  output logic [ADDR_W-1:0]        pc
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_instr_pc;
  logic [DATA_W-1:0]   r_ir;
  logic                r_valid;
  logic                r_halted;

  logic                w_accept;
  logic [ADDR_W-1:0]   w_pc_inc;

  assign w_accept = r_valid & instr_ready;
  assign w_pc_inc = r_pc + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_pc       <= ADDR_W'(RESET_PC);
      r_instr_pc <= '0;
      r_ir       <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (halt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALTED;
          end else begin
            r_ir       <= rom_data;
            r_instr_pc <= r_pc;
            r_pc       <= w_pc_inc;
            r_valid    <= 1'b1;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          // A presented instruction is only retired by an accept, even under halt.
          if (w_accept) begin
            if (jump_en) begin
              r_pc <= jump_addr;
            end
            if (halt) begin
              r_valid  <= 1'b0;
              r_halted <= 1'b1;
              r_state  <= S_HALTED;
            end else if (jump_en) begin
              r_valid <= 1'b0;
              r_state <= S_FETCH;
            end else begin
              r_ir       <= rom_data;
              r_instr_pc <= r_pc;
              r_pc       <= w_pc_inc;
            end
          end
        end
        S_HALTED: begin
          r_valid <= 1'b0;
          if (!halt) begin
            r_halted <= 1'b0;
            r_state  <= S_FETCH;
          end
        end
        default: begin
          r_valid  <= 1'b0;
          r_halted <= 1'b0;
          r_state  <= S_FETCH;
        end
      endcase
    end
  end

  // ROM address is the live PC so the word is captured on the same edge.
  assign rom_addr    = r_pc;
  assign pc          = r_pc;
  assign instr_valid = r_valid;
  assign instr_pc    = r_instr_pc;
  assign opcode      = r_ir[DATA_W-1:ADDR_W];
  assign imm         = r_ir[ADDR_W-1:0];
  assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with fixed expectations plus a
// randomized run checked against a rule-level model of the fetch stage.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [3:0] opcode;
  logic [3:0] imm;
  logic [3:0] instr_pc;
  logic       jump_en = 1'b0;
  logic [3:0] jump_addr = 4'h0;
  logic       halt = 1'b0;
  logic       halted;
  logic [3:0] pc;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rom [16];

  // Model state: next fetch address, presented instruction, halted flag.
  logic [3:0] m_pc;
  logic [7:0] m_ir;
  logic [3:0] m_ipc;
  logic       m_valid;
  logic       m_halted;

  // Observed fields, hex-printed as {valid,halted} pc instr_pc opcode imm.
  logic [17:0] w_obs;
  logic [17:0] e;
  assign w_obs = {instr_valid, halted, pc, instr_pc, opcode, imm};
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(4), .DATA_W(8), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode(opcode),
    .imm(imm), .instr_pc(instr_pc), .jump_en(jump_en), .jump_addr(jump_addr),
    .halt(halt), .halted(halted), .pc(pc)
  );

  task automatic model_reset();
    m_pc = 4'h0; m_ir = 8'h00; m_ipc = 4'h0; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  task automatic model_load();
    m_ir = rom[m_pc]; m_ipc = m_pc; m_pc = m_pc + 4'h1; m_valid = 1'b1;
  endtask

  // One clock: the model applies the fetch rules to the inputs seen at the edge.
  task automatic cycle();
    logic acc;
    @(posedge clk);
    acc = m_valid && instr_ready;
    if (m_halted) begin
      if (!halt) m_halted = 1'b0;
    end else if (!m_valid) begin
      if (halt) m_halted = 1'b1;
      else model_load();
    end else if (acc) begin
      if (jump_en) m_pc = jump_addr;
      if (halt) begin m_valid = 1'b0; m_halted = 1'b1; end
      else if (jump_en) m_valid = 1'b0;
      else model_load();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; halt = 1'b0; jump_addr = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    e = 18'h0; n_tests++;
    if (w_obs !== e) begin n_fail++; $display("FAIL reset_state got %h exp %h", w_obs, e); end
    instr_ready = 1'b1;
    cycle();
    e = {2'b10, 4'h1, 4'h0, 4'h3, 4'h0}; n_tests++;
    if (w_obs !== e) begin n_fail++; $display("FAIL first_valid got %h exp %h", w_obs, e); end
  endtask

  task automatic test_stream();
    logic [7:0] words [3];
    words[0] = 8'h60; words[1] = 8'hC0; words[2] = 8'h5F;
    for (int i = 0; i < 3; i++) begin
      cycle();
      e = {2'b10, 4'(i + 2), 4'(i + 1), words[i]}; n_tests++;
      if (w_obs !== e) begin n_fail++; $display("FAIL stream_%0d got %h exp %h", i + 1, w_obs, e); end
    end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      e = {2'b10, 4'h4, 4'h3, 8'h5F}; n_tests++;
      if (w_obs !== e) begin n_fail++; $display("FAIL stall_hold_%0d got %h exp %h", i, w_obs, e); end
    end
    instr_ready = 1'b1;
    cycle();
    e = {2'b10, 4'h5, 4'h4, 8'hF2}; n_tests++;
    if (w_obs !== e) begin n_fail++; $display("FAIL stall_release got %h exp %h", w_obs, e); end
  endtask

  task automatic test_jump();
    jump_en = 1'b1; jump_addr = 4'h2;
    cycle();
    e = {2'b00, 4'h2, 4'h4, 8'hF2}; n_tests++;
    if (w_obs !== e) begin n_fail++; $display("FAIL jump_bubble got %h exp %h", w_obs, e); end
    jump_en = 1'b0;
    cycle();
    e = {2'b10, 4'h3, 4'h2, 8'hC0}; n_tests++;
    if (w_obs !== e) begin n_fail++; $display("FAIL jump_target got %h exp %h", w_obs, e); end
    instr_ready = 1'b0; jump_en = 1'b1; jump_addr = 4'h9;
    cycle();
    n_tests++;
    if (w_obs !== e) begin n_fail++; $display("FAIL jump_no_accept got %h exp %h", w_obs, e); end
    jump_en = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    instr_ready = 1'b1;
    repeat (16) cycle();
    e = {2'b10, 4'h0, 4'hF, 8'h00}; n_tests++;
    if (w_obs !== e) begin n_fail++; $display("FAIL wrap_last got %h exp %h", w_obs, e); end
    cycle();
    e = {2'b10, 4'h1, 4'h0, 8'h30}; n_tests++;
    if (w_obs !== e) begin n_fail++; $display("FAIL wrap_first got %h exp %h", w_obs, e); end
  endtask

  task automatic test_halt();
    do_reset();
    instr_ready = 1'b1;
    repeat (2) cycle();
    instr_ready = 1'b0; halt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      e = {2'b10, 4'h2, 4'h1, 8'h60}; n_tests++;
      if (w_obs !== e) begin n_fail++; $display("FAIL halt_pending_%0d got %h exp %h", i, w_obs, e); end
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      e = {2'b01, 4'h2, 4'h1, 8'h60}; n_tests++;
      if (w_obs !== e) begin n_fail++; $display("FAIL halt_stopped_%0d got %h exp %h", i, w_obs, e); end
    end
    halt = 1'b0;
    cycle();
    e = {2'b00, 4'h2, 4'h1, 8'h60}; n_tests++;
    if (w_obs !== e) begin n_fail++; $display("FAIL halt_resume got %h exp %h", w_obs, e); end
    cycle();
    e = {2'b10, 4'h3, 4'h2, 8'hC0}; n_tests++;
    if (w_obs !== e) begin n_fail++; $display("FAIL halt_refetch got %h exp %h", w_obs, e); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    instr_ready = 1'b1;
    repeat (6) cycle();
    e = {2'b10, 4'h6, 4'h5, 8'h80}; n_tests++;
    if (w_obs !== e) begin n_fail++; $display("FAIL pre_reset got %h exp %h", w_obs, e); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    e = 18'h0; n_tests++;
    if (w_obs !== e) begin n_fail++; $display("FAIL async_reset got %h exp %h", w_obs, e); end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    e = {2'b10, 4'h1, 4'h0, 8'h30}; n_tests++;
    if (w_obs !== e) begin n_fail++; $display("FAIL post_reset got %h exp %h", w_obs, e); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      instr_ready = ($urandom_range(3) != 0);
      jump_en     = ($urandom_range(4) == 0);
      jump_addr   = 4'($urandom_range(15));
      halt        = ($urandom_range(6) == 0);
      cycle();
      e = {m_valid, m_halted, m_pc, m_ipc, m_ir}; n_tests++;
      if (w_obs !== e) begin n_fail++; $display("FAIL random_%0d got %h exp %h", i, w_obs, e); end
      n_tests++;
      if (rom_addr !== m_pc) begin n_fail++; $display("FAIL random_romaddr_%0d got %h exp %h", i, rom_addr, m_pc); end
    end
    halt = 1'b0; jump_en = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 16; a++) rom[a] = 8'h00;
    rom[0] = 8'h30; rom[1] = 8'h60; rom[2] = 8'hC0; rom[3] = 8'h5F;
    rom[4] = 8'hF2; rom[5] = 8'h80; rom[6] = 8'hA0;
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_jump();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
